// File: rtl/mat_pkg.sv
// Shared types and sizing for the mat_mult operand loader.
// One frame carries matrix A then matrix B, row-major, one element per transfer.
package mat_pkg;
    localparam int ELEM_W    = 8;
    localparam int N         = 3;
    localparam int MAT_W     = N * N * ELEM_W;
    localparam int FRAME_LEN = 2 * N * N;
    localparam int CNT_W     = $clog2(N * N);

    typedef logic [MAT_W-1:0] mat_t;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        WAIT
    } ld_state_t;
endpackage

// File: rtl/mat_shift_reg.sv
// Matrix assembly register: each enabled cycle shifts one element in at the LSBs,
// so the first element ends up at the MSBs once N*N elements have arrived.
module mat_shift_reg
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ELEM_W-1:0] din,
    output mat_t              q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[MAT_W-ELEM_W-1:0], din};
        end
    end

endmodule

// File: rtl/mat_stream_loader.sv
// Byte-stream to operand-pair loader for mat_mult, with a registered output stage
// so the next frame can assemble while the current pair waits for the consumer.
module mat_stream_loader
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output mat_t              out_A,
    output mat_t              out_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output ld_state_t         ld_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; the producer holds data stable until then, ready never depends on valid.

    ld_state_t        state_q;
    logic [CNT_W-1:0] elem_cnt;
    mat_t             asm_a;
    mat_t             asm_b;
    logic             accept;
    logic             at_end;
    logic             bad;
    logic             shift_a;
    logic             shift_b;

    assign ld_state = state_q;
    assign accept   = in_valid && in_ready;
    assign at_end   = (elem_cnt == CNT_W'(N * N - 1));

    // in_last is only legal on the final B element, and required there.
    assign bad = accept &&
                 (((state_q == LOAD_A) && in_last) ||
                  ((state_q == LOAD_B) && (in_last != at_end)));

    assign shift_a = accept && (state_q == LOAD_A) && !bad;
    assign shift_b = accept && (state_q == LOAD_B) && !bad;

    mat_shift_reg u_asm_a (
        .clk (clk),
        .rst (rst),
        .clr (bad),
        .en  (shift_a),
        .din (in_data),
        .q   (asm_a)
    );

    mat_shift_reg u_asm_b (
        .clk (clk),
        .rst (rst),
        .clr (bad),
        .en  (shift_b),
        .din (in_data),
        .q   (asm_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD_A;
            elem_cnt  <= '0;
            in_ready  <= 1'b1;
            out_A     <= '0;
            out_B     <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_q)
                LOAD_A: begin
                    if (bad) begin
                        elem_cnt <= '0;
                    end else if (accept) begin
                        if (at_end) begin
                            state_q  <= LOAD_B;
                            elem_cnt <= '0;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (bad) begin
                        state_q  <= LOAD_A;
                        elem_cnt <= '0;
                    end else if (accept) begin
                        if (at_end) begin
                            state_q  <= WAIT;
                            in_ready <= 1'b0;
                            elem_cnt <= '0;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Overrides the consume-clear above when a new pair replaces the old one.
                    if (!out_valid || out_ready) begin
                        out_A     <= asm_a;
                        out_B     <= asm_b;
                        out_valid <= 1'b1;
                        state_q   <= LOAD_A;
                        in_ready  <= 1'b1;
                        elem_cnt  <= '0;
                    end
                end
                default: begin
                    state_q  <= LOAD_A;
                    in_ready <= 1'b1;
                    elem_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_stream_loader.sv
// Directed bench for mat_stream_loader: framing, latency, backpressure, gaps and reset.
module tb_mat_stream_loader;
    import mat_pkg::*;

    localparam mat_t A1 = 72'h030101020109090509;
    localparam mat_t B1 = 72'h0A0301010401090905;

    logic              clk = 1'b0;
    logic              rst;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    mat_t              out_A;
    mat_t              out_B;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    ld_state_t         ld_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mat_stream_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_A     (out_A),
        .out_B     (out_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .ld_state  (ld_state)
    );

    task automatic check(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send(input logic [ELEM_W-1:0] d, input logic l);
        int budget;
        budget   = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 200) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input mat_t a, input mat_t b, input bit gap);
        logic [ELEM_W-1:0] e;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i < N * N) e = a[MAT_W-1-ELEM_W*i -: ELEM_W];
            else           e = b[MAT_W-1-ELEM_W*(i-N*N) -: ELEM_W];
            if (gap && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send(e, i == FRAME_LEN - 1);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    initial begin
        bit seen_valid;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_A", out_A, 0);
        check("rst_out_B", out_B, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", ld_state, LOAD_A);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame: out_valid two cycles after the last accept.
        send_frame(A1, B1, 0);
        check("basic_valid_t1", out_valid, 0);
        check("basic_ready_t1", in_ready, 0);
        check("basic_state_t1", ld_state, WAIT);
        @(posedge clk); #1;
        check("basic_valid_t2", out_valid, 1);
        check("basic_out_A", out_A, A1);
        check("basic_out_B", out_B, B1);
        check("basic_ready_t2", in_ready, 1);
        check("basic_err", frame_err, 0);
        @(posedge clk); #1;
        check("basic_consumed", out_valid, 0);

        // Backpressure: two frames with the consumer stalled.
        out_ready = 1'b0;
        send_frame(A1, B1, 0);
        send_frame(B1, A1, 0);
        check("bp_ready_drop", in_ready, 0);
        check("bp_state_wait", ld_state, WAIT);
        repeat (3) @(posedge clk);
        #1;
        check("bp_ready_held", in_ready, 0);
        check("bp_valid_held", out_valid, 1);
        check("bp_A_frame1", out_A, A1);
        check("bp_B_frame1", out_B, B1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_cont", out_valid, 1);
        check("bp_A_frame2", out_A, B1);
        check("bp_B_frame2", out_B, A1);
        check("bp_ready_back", in_ready, 1);
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);

        // Early last on element 5.
        for (int i = 0; i < 5; i++) send(A1[MAT_W-1-ELEM_W*i -: ELEM_W], i == 4);
        check("early_err_pulse", frame_err, 1);
        check("early_state", ld_state, LOAD_A);
        check("early_no_valid", out_valid, 0);
        @(posedge clk); #1;
        check("early_err_single", frame_err, 0);
        send_frame(A1, B1, 0);
        wait_valid("early_recover_valid");
        check("early_recover_A", out_A, A1);
        check("early_recover_B", out_B, B1);
        @(posedge clk); #1;

        // Missing last: 18 elements, none flagged.
        for (int i = 0; i < FRAME_LEN; i++) send(8'(i + 1), 1'b0);
        check("miss_err_pulse", frame_err, 1);
        check("miss_state", ld_state, LOAD_A);
        check("miss_in_ready", in_ready, 1);
        seen_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("miss_no_output", seen_valid, 0);
        check("miss_err_cleared", frame_err, 0);

        // Gapped input.
        send_frame(A1, B1, 1);
        wait_valid("gap_valid");
        check("gap_out_A", out_A, A1);
        check("gap_out_B", out_B, B1);
        @(posedge clk); #1;

        // Reset mid-frame with a pair held at the output.
        out_ready = 1'b0;
        send_frame(A1, B1, 0);
        wait_valid("rstmid_pre_valid");
        for (int i = 0; i < 7; i++) send(B1[MAT_W-1-ELEM_W*i -: ELEM_W], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_out_A", out_A, 0);
        check("rstmid_out_B", out_B, 0);
        check("rstmid_state", ld_state, LOAD_A);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send_frame(B1, A1, 0);
        wait_valid("rstmid_after_valid");
        check("rstmid_after_A", out_A, B1);
        check("rstmid_after_B", out_B, A1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
